sevenseg_scan_decoder: RTL and testbench

- Reverse-direction companion to the BCD-to-segment decoder.
- Watches a multiplexed, active-low 7-segment bus and its active-low digit anodes, and rebuilds the 4-bit digit value shown on each position.
- Used as an on-chip display monitor and self-check for the stopwatch: it samples the scanned bus, filters scan transitions with a stability counter, and keeps one decoded register per digit.

---
 rtl/sevenseg_scan_decoder.sv | 124 ++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
// Monitors a multiplexed, active-low 7-segment bus with active-low digit
// anodes and rebuilds the 4-bit value shown on each digit position. Scan
// transitions are filtered by a stability counter so that only a bus state
// held long enough is committed into the per-digit registers.
module sevenseg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              ledsegments,
  input  logic [NUM_DIGITS-1:0]   anodes,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    pattern_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam int SW = NUM_DIGITS + 7;

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_an;
  logic [SW-1:0]         prev;
  logic [CW-1:0]         cnt;

  logic                  stable;
  logic                  commit;
  logic                  an_one_low;
  logic                  an_all_high;
  logic [3:0]            dec_value;
  logic                  dec_valid;
  logic                  dec_illegal;

  // Input sampling stage: the bus is registered before anything looks at it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_seg <= 7'h7F;
      s_an  <= '1;
    end else begin
      s_seg <= ledsegments;
      s_an  <= anodes;
    end
  end

  // Stability counter: restarts on any change and saturates once the sample is trusted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= {{NUM_DIGITS{1'b1}}, 7'h7F};
      cnt  <= '0;
    end else begin
      prev <= {s_an, s_seg};
      if (!stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Commit fires only on the step into saturation, so a long hold writes once.
  always_comb begin
    stable      = ({s_an, s_seg} == prev);
    commit      = stable && (cnt == CNT_LAST);
    an_one_low  = $onehot(~s_an);
    an_all_high = &s_an;
  end

  // Segment pattern decode; blank is a legal non-digit, anything else unknown is an error.
  always_comb begin
    dec_value   = 4'hE;
    dec_valid   = 1'b0;
    dec_illegal = 1'b0;
    case (s_seg)
      7'h40: begin dec_value = 4'd0; dec_valid = 1'b1; end
      7'h79: begin dec_value = 4'd1; dec_valid = 1'b1; end
      7'h24: begin dec_value = 4'd2; dec_valid = 1'b1; end
      7'h30: begin dec_value = 4'd3; dec_valid = 1'b1; end
      7'h19: begin dec_value = 4'd4; dec_valid = 1'b1; end
      7'h12: begin dec_value = 4'd5; dec_valid = 1'b1; end
      7'h02: begin dec_value = 4'd6; dec_valid = 1'b1; end
      7'h78: begin dec_value = 4'd7; dec_valid = 1'b1; end
      7'h00: begin dec_value = 4'd8; dec_valid = 1'b1; end
      7'h10: begin dec_value = 4'd9; dec_valid = 1'b1; end
      7'h7F: begin dec_value = 4'hF; dec_valid = 1'b0; end
      default: begin
        dec_value   = 4'hE;
        dec_valid   = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Per-digit registers and the one-cycle status pulses produced at commit time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= '1;
      digit_valid <= '0;
      update      <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      update      <= 1'b0;
      pattern_err <= 1'b0;
      if (commit) begin
        if (an_one_low) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) begin
              digits[4*i +: 4] <= dec_value;
              digit_valid[i]   <= dec_valid;
            end
          end
          update      <= 1'b1;
          pattern_err <= dec_illegal;
        end else if (!an_all_high) begin
          pattern_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder
// Directed stimulus pushes expected commits into a scoreboard queue; a
// monitor pops an entry whenever the DUT pulses update or pattern_err.
module tb_sevenseg_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  ledsegments;
  logic [3:0]  anodes;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic        pattern_err;

  typedef struct {
    int          cycle;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        upd;
    logic        err;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  sevenseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .ledsegments (ledsegments),
    .anodes      (anodes),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .pattern_err (pattern_err)
  );

  // Free-running clock and edge counter used to timestamp commits.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every pulse must match the next scoreboard entry, including its edge number.
  always @(negedge clk) begin
    if (!reset && (update || pattern_err)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got update=%0b pattern_err=%0b at edge %0d expected no pulse",
                 update, pattern_err, cyc);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput({mon_e.name, "_edge"},   cyc,         mon_e.cycle);
        checkOutput({mon_e.name, "_digits"}, digits,      mon_e.digits);
        checkOutput({mon_e.name, "_valid"},  digit_valid, mon_e.valid);
        checkOutput({mon_e.name, "_update"}, update,      mon_e.upd);
        checkOutput({mon_e.name, "_perr"},   pattern_err, mon_e.err);
      end
    end
  end

  // Drive one bus state for 'hold' edges; if a commit is expected, queue it
  // for edge k+STABLE+1 where k is the first edge that samples the new state.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int hold,
                               input logic expect_pulse, input logic [15:0] exp_digits,
                               input logic [3:0] exp_valid, input logic exp_upd,
                               input logic exp_err, input string name);
    exp_t e;
    @(negedge clk);
    anodes      = an;
    ledsegments = seg;
    if (expect_pulse) begin
      e.cycle  = cyc + 1 + STABLE + 1;
      e.digits = exp_digits;
      e.valid  = exp_valid;
      e.upd    = exp_upd;
      e.err    = exp_err;
      e.name   = name;
      sbq.push_back(e);
    end
    repeat (hold) @(posedge clk);
  endtask

  task automatic blankGap(input int hold);
    applyStimulus(4'b1111, 7'h7F, hold, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, "blank");
  endtask

  initial begin
    reset       = 1'b1;
    anodes      = 4'b1111;
    ledsegments = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_digits", digits,      16'hFFFF);
    checkOutput("reset_valid",  digit_valid, 4'h0);
    checkOutput("reset_update", update,      1'b0);
    checkOutput("reset_perr",   pattern_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // First commit five edges after the value appears, then silence while held.
    applyStimulus(4'b1110, 7'h24, 12, 1'b1, 16'hFFF2, 4'b0001, 1'b1, 1'b0, "first_two");
    blankGap(2);

    // Full scan with short blanking gaps between digits.
    applyStimulus(4'b1110, 7'h79, 8, 1'b1, 16'hFFF1, 4'b0001, 1'b1, 1'b0, "scan_d0");
    blankGap(2);
    applyStimulus(4'b1101, 7'h30, 8, 1'b1, 16'hFF31, 4'b0011, 1'b1, 1'b0, "scan_d1");
    blankGap(2);
    applyStimulus(4'b1011, 7'h12, 8, 1'b1, 16'hF531, 4'b0111, 1'b1, 1'b0, "scan_d2");
    blankGap(2);
    applyStimulus(4'b0111, 7'h10, 8, 1'b1, 16'h9531, 4'b1111, 1'b1, 1'b0, "scan_d3");
    blankGap(8);

    // Four-edge hold is a glitch; five edges is just enough.
    applyStimulus(4'b1101, 7'h24, 4, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, "glitch");
    blankGap(8);
    checkOutput("glitch_digits", digits,      16'h9531);
    checkOutput("glitch_valid",  digit_valid, 4'b1111);
    applyStimulus(4'b1101, 7'h24, 5, 1'b1, 16'h9521, 4'b1111, 1'b1, 1'b0, "hold5");
    blankGap(8);

    // Illegal segment pattern on a legal anode: write E plus both pulses.
    applyStimulus(4'b1110, 7'h55, 8, 1'b1, 16'h952E, 4'b1110, 1'b1, 1'b1, "illegal_seg");
    blankGap(2);

    // Two anodes low: error only; then a blank write to digit 2.
    applyStimulus(4'b1100, 7'h40, 8, 1'b1, 16'h952E, 4'b1110, 1'b0, 1'b1, "multi_anode");
    applyStimulus(4'b1011, 7'h7F, 8, 1'b1, 16'h9F2E, 4'b1010, 1'b1, 1'b0, "blank_d2");
    blankGap(8);

    // Reset while the counter sits at 3 during a digit-1 hold.
    @(negedge clk);
    anodes      = 4'b1101;
    ledsegments = 7'h79;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_digits", digits,      16'hFFFF);
    checkOutput("midreset_valid",  digit_valid, 4'h0);
    checkOutput("midreset_update", update,      1'b0);
    checkOutput("midreset_perr",   pattern_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    begin
      exp_t e;
      e.cycle  = cyc + 1 + STABLE + 1;
      e.digits = 16'hFF1F;
      e.valid  = 4'b0010;
      e.upd    = 1'b1;
      e.err    = 1'b0;
      e.name   = "after_reset";
      sbq.push_back(e);
    end
    repeat (10) @(posedge clk);
    blankGap(8);

    @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
